bram_port_arbiter: RTL and testbench

//  Shares port A of the 4096x32 dual-port block RAM between two requesters: port 0 (instruction fetch, read-only)
//  and port 1 (data bus, read/write with byte strobes). The RAM has a single word-wide write enable,
//  so partial writes are done as a read-modify-write (RMW). One operation is in flight at a time.

---
 rtl/bram_ctrl_pkg.sv | 38 +++
 rtl/bram_rr_arb2.sv | 43 ++++
 rtl/bram_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bram_ctrl_pkg
// Shared types and helpers for the block-RAM port-A arbiter.
//   state_t      : controller FSM encoding (also visible on the debug state port)
//   BE_FULL      : byte-enable value meaning "write the whole word"
//   LANE_W       : bits per byte lane
//   NUM_LANES    : byte lanes per 32-bit word
//   merge_lanes  : per-lane select between new write data and old RAM data
// -----------------------------------------------------------------------------
package bram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        WR       = 3'd2,
        RMW_RD   = 3'd3,
        RMW_WAIT = 3'd4,
        RMW_WR   = 3'd5,
        ACK      = 3'd6
    } state_t;

    localparam logic [3:0] BE_FULL   = 4'hF;
    localparam int         LANE_W    = 8;
    localparam int         NUM_LANES = 4;

    // Lane i takes the new byte when be[i] is set, otherwise keeps the old byte.
    function automatic logic [31:0] merge_lanes(input logic [3:0]  be,
                                                input logic [31:0] new_w,
                                                input logic [31:0] old_w);
        logic [31:0] m;
        m = old_w;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (be[i]) m[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
        end
        return m;
    endfunction

endpackage

// File: rtl/bram_rr_arb2.sv
// -----------------------------------------------------------------------------
// bram_rr_arb2
// Two-way round-robin arbiter. Grants only while idle_i is high and only to
// ports whose request is raised. On contention the port that did not win last
// time is chosen. The remembered winner resets to port 1, so port 0 takes the
// first contention after reset.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   idle_i      : owner is free to accept a request this cycle
//   req_i[1:0]  : request per port
//   grant_o[1:0]: one-hot grant (combinational); a grant is an accept
// -----------------------------------------------------------------------------
module bram_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       idle_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    logic last_grant_q;   // 1 = port 1 won the most recent accept

    always_comb begin
        grant_o = 2'b00;
        if (idle_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (grant_o != 2'b00) begin
            last_grant_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
// Shares port A of a 4096x32 dual-port block RAM between an instruction-fetch
// read port (port 0) and a data port with byte strobes (port 1). One operation
// is in flight at a time. Partial writes are done as read-modify-write because
// the RAM has a single word-wide write enable.
//
// Handshake: a request is accepted in any cycle where reqN_valid & reqN_ready
// are both high at the rising edge. reqN_ready is combinational, high only
// while the controller is IDLE and the arbiter selects port N (never without
// reqN_valid). rspN_valid is a one-cycle pulse with no back-pressure; for
// port-1 writes it is an acknowledge with rsp1_rdata = 0.
//
// Ports:
//   clk, rst_n                  clock (also RAM clka), async active-low reset
//   req0_valid/ready/addr       port 0 read request
//   rsp0_valid/rdata            port 0 read response
//   req1_valid/ready/addr/we/be/wdata  port 1 request
//   rsp1_valid/rdata            port 1 read data or write acknowledge
//   ram_ce/oce/wre/ad/din       registered RAM port-A controls
//   ram_dout                    RAM port-A read data (RD_LATENCY after sample)
//   state_o                     controller state, for debug visibility
// -----------------------------------------------------------------------------
module bram_port_arbiter
    import bram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_we,
    input  logic [3:0]        req1_be,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [2:0]        state_o
);

    localparam int              CNT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;        // cycles until ram_dout holds the issued read
    logic                port_q;       // owner of the in-flight operation
    logic [3:0]          be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rsp0_valid_q;
    logic                rsp1_valid_q;
    logic                rsp_rd_q;     // pending response carries RAM read data
    logic                ram_ce_q;
    logic                ram_oce_q;
    logic                ram_wre_q;
    logic [ADDR_W-1:0]   ram_ad_q;
    logic [DATA_W-1:0]   ram_din_q;

    logic [1:0]          grant;

    bram_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .idle_i  (state_q == IDLE),
        .req_i   ({req1_valid, req0_valid}),
        .grant_o (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Read data is passed straight from the RAM output register in the cycle
    // it becomes valid; the FSM is already back in IDLE then.
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = (rsp0_valid_q && rsp_rd_q) ? ram_dout : '0;
    assign rsp1_rdata = (rsp1_valid_q && rsp_rd_q) ? ram_dout : '0;

    assign ram_ce  = ram_ce_q;
    assign ram_oce = ram_oce_q;
    assign ram_wre = ram_wre_q;
    assign ram_ad  = ram_ad_q;
    assign ram_din = ram_din_q;
    assign state_o = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            port_q       <= 1'b0;
            be_q         <= 4'h0;
            wdata_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_rd_q     <= 1'b0;
            ram_ce_q     <= 1'b0;
            ram_oce_q    <= 1'b1;
            ram_wre_q    <= 1'b0;
            ram_ad_q     <= '0;
            ram_din_q    <= '0;
        end else begin
            // RAM strobes and response pulses last exactly one cycle.
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_rd_q     <= 1'b0;
            ram_ce_q     <= 1'b0;
            ram_wre_q    <= 1'b0;
            ram_oce_q    <= 1'b1;
            if (cnt_q != CNT_ZERO) cnt_q <= cnt_q - CNT_ONE;

            case (state_q)
                IDLE: begin
                    if (grant[0]) begin
                        port_q   <= 1'b0;
                        ram_ad_q <= req0_addr;
                        ram_ce_q <= 1'b1;
                        cnt_q    <= CNT_LOAD;
                        state_q  <= RD_WAIT;
                    end else if (grant[1]) begin
                        port_q   <= 1'b1;
                        ram_ad_q <= req1_addr;
                        be_q     <= req1_be;
                        wdata_q  <= req1_wdata;
                        if (!req1_we) begin
                            ram_ce_q <= 1'b1;
                            cnt_q    <= CNT_LOAD;
                            state_q  <= RD_WAIT;
                        end else if (req1_be == BE_FULL) begin
                            ram_ce_q  <= 1'b1;
                            ram_wre_q <= 1'b1;
                            ram_din_q <= req1_wdata;
                            state_q   <= WR;
                        end else if (req1_be == 4'h0) begin
                            // Nothing to write: acknowledge without touching the RAM.
                            rsp1_valid_q <= 1'b1;
                        end else begin
                            ram_ce_q <= 1'b1;
                            cnt_q    <= CNT_LOAD;
                            state_q  <= RMW_RD;
                        end
                    end
                end

                RD_WAIT: begin
                    // Leave one cycle early: the registered response pulse
                    // lines up with the cycle ram_dout is valid.
                    if (cnt_q == CNT_ONE) begin
                        rsp_rd_q <= 1'b1;
                        if (port_q) rsp1_valid_q <= 1'b1;
                        else        rsp0_valid_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end

                WR: begin
                    rsp1_valid_q <= 1'b1;
                    state_q      <= IDLE;
                end

                RMW_RD: begin
                    state_q <= RMW_WAIT;
                end

                RMW_WAIT: begin
                    // Counter reaches zero in the cycle the old word is on ram_dout.
                    if (cnt_q == CNT_ZERO) begin
                        ram_din_q <= merge_lanes(be_q, wdata_q, ram_dout);
                        ram_ce_q  <= 1'b1;
                        ram_wre_q <= 1'b1;
                        state_q   <= RMW_WR;
                    end
                end

                RMW_WR: begin
                    rsp1_valid_q <= 1'b1;
                    state_q      <= IDLE;
                end

                ACK: begin
                    rsp1_valid_q <= 1'b1;
                    state_q      <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
// Directed bench for bram_port_arbiter with a behavioural 2-cycle RAM model.
// Drivers push the expected response data and response cycle into per-port
// queues at accept time; independent monitors pop and compare on rspN_valid.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;
  import bram_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        req0_valid = 1'b0, req0_ready;
  logic [11:0] req0_addr = '0;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid = 1'b0, req1_ready;
  logic [11:0] req1_addr = '0;
  logic        req1_we = 1'b0;
  logic [3:0]  req1_be = '0;
  logic [31:0] req1_wdata = '0;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        ram_ce, ram_oce, ram_wre;
  logic [11:0] ram_ad;
  logic [31:0] ram_din, ram_dout;
  logic [2:0]  state_o;

  bram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_we(req1_we), .req1_be(req1_be), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout),
    .state_o(state_o)
  );

  // ---------------- RAM model (pipelined, 2-cycle read) ----------------
  logic [31:0] mem [0:4095];
  logic [31:0] s1_q, dout_q;
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_ce) begin
      if (ram_wre) mem[ram_ad] <= ram_din;
      else         s1_q <= mem[ram_ad];
    end
    if (ram_oce) dout_q <= s1_q;
  end
  assign ram_dout = dout_q;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  int exp0_cyc_q[$];
  int exp1_cyc_q[$];
  int grant_log[$];
  int ce_cnt = 0, wre_cnt = 0, last_ce_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (ram_ce) begin
      ce_cnt++;
      last_ce_cyc = cyc;
      if (ram_wre) wre_cnt++;
    end
  end

  always @(negedge clk) begin : mon0
    logic [31:0] e;
    int ec;
    if (rst_n && rsp0_valid) begin
      if (exp0_q.size() == 0) begin
        n_checks++;
        $display("FAIL rsp0_unexpected: actual rsp0_valid=1 rdata=%h at cycle %0d, required no response", rsp0_rdata, cyc);
      end else begin
        e = exp0_q.pop_front();
        ec = exp0_cyc_q.pop_front();
        chk("rsp0_rdata", rsp0_rdata, e);
        chk("rsp0_cycle", cyc, ec);
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [31:0] e;
    int ec;
    if (rst_n && rsp1_valid) begin
      if (exp1_q.size() == 0) begin
        n_checks++;
        $display("FAIL rsp1_unexpected: actual rsp1_valid=1 rdata=%h at cycle %0d, required no response", rsp1_rdata, cyc);
      end else begin
        e = exp1_q.pop_front();
        ec = exp1_cyc_q.pop_front();
        chk("rsp1_rdata", rsp1_rdata, e);
        chk("rsp1_cycle", cyc, ec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic issue0(input logic [11:0] addr, input logic [31:0] exp, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = addr;
    #1;
    while (!req0_ready && t < 60) begin
      @(negedge clk); #1; t++;
    end
    if (!req0_ready) begin
      n_checks++;
      $display("FAIL req0_accept: ready=0 required=1 after %0d cycles", t);
      req0_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      grant_log.push_back(0);
      exp0_q.push_back(exp);
      exp0_cyc_q.push_back(cyc + 3);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req0_addr = 12'($urandom);
    end
  endtask

  // lat = cycles from accept to rsp1_valid; lat = 0 means no response expected.
  task automatic issue1(input logic [11:0] addr, input logic we, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [31:0] exp, input int lat,
                        output int acc);
    int t;
    t = 0;
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = addr; req1_we = we; req1_be = be; req1_wdata = wdata;
    #1;
    while (!req1_ready && t < 60) begin
      @(negedge clk); #1; t++;
    end
    if (!req1_ready) begin
      n_checks++;
      $display("FAIL req1_accept: ready=0 required=1 after %0d cycles", t);
      req1_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      grant_log.push_back(1);
      if (lat > 0) begin
        exp1_q.push_back(exp);
        exp1_cyc_q.push_back(cyc + lat);
      end
      @(posedge clk); #1;
      // Scramble fields after accept; the DUT must use the captured copy.
      req1_valid = 1'b0;
      req1_addr  = 12'($urandom);
      req1_be    = 4'($urandom_range(0, 15));
      req1_wdata = $urandom;
      req1_we    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && t < 100) begin
      @(negedge clk); t++;
    end
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: outstanding=%0d/%0d required=0/0", exp0_q.size(), exp1_q.size());
      exp0_q.delete(); exp1_q.delete(); exp0_cyc_q.delete(); exp1_cyc_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ram_ce"},  32'(ram_ce), 32'd0);
    chk({tag, "_ram_wre"}, 32'(ram_wre), 32'd0);
    chk({tag, "_ram_oce"}, 32'(ram_oce), 32'd1);
    chk({tag, "_ram_ad"},  32'(ram_ad), 32'd0);
    chk({tag, "_ram_din"}, ram_din, 32'd0);
    chk({tag, "_rsp0_valid"}, 32'(rsp0_valid), 32'd0);
    chk({tag, "_rsp0_rdata"}, rsp0_rdata, 32'd0);
    chk({tag, "_rsp1_valid"}, 32'(rsp1_valid), 32'd0);
    chk({tag, "_rsp1_rdata"}, rsp1_rdata, 32'd0);
    chk({tag, "_state"}, 32'(state_o), 32'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int a, b, ce0, wre0, base;

    rst_n = 1'b0;
    preload(12'h010, 32'hDEADBEEF);
    preload(12'h030, 32'hAABBCCDD);
    preload(12'h050, 32'h01020304);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Port-0 read: data in I+3, single RAM enable in I+1.
    ce0 = ce_cnt;
    issue0(12'h010, 32'hDEADBEEF, a);
    drain();
    chk("read0_ce_count", 32'(ce_cnt - ce0), 32'd1);
    chk("read0_ce_cycle", 32'(last_ce_cyc), 32'(a + 1));

    // Full write then read back.
    issue1(12'h020, 1'b1, 4'hF, 32'h12345678, 32'h0, 2, a);
    issue1(12'h020, 1'b0, 4'h0, 32'h0, 32'h12345678, 3, a);
    drain();

    // Partial write via read-modify-write.
    wre0 = wre_cnt;
    issue1(12'h030, 1'b1, 4'b0101, 32'h11223344, 32'h0, 5, a);
    drain();
    chk("rmw_mem_030", mem[12'h030], 32'hAA22CC44);
    chk("rmw_wre_count", 32'(wre_cnt - wre0), 32'd1);
    issue1(12'h030, 1'b0, 4'h0, 32'h0, 32'hAA22CC44, 3, a);
    drain();

    // Continuous contention: last winner was port 1, so port 0 goes first.
    base = grant_log.size();
    fork
      begin
        int x;
        issue0(12'h010, 32'hDEADBEEF, x);
        issue0(12'h020, 32'h12345678, x);
        issue0(12'h030, 32'hAA22CC44, x);
      end
      begin
        int y;
        issue1(12'h040, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 2, y);
        issue1(12'h040, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D, 3, y);
        issue1(12'h040, 1'b1, 4'b1000, 32'h55000000, 32'h0, 5, y);
      end
    join
    drain();
    chk("rr_grant_count", 32'(grant_log.size() - base), 32'd6);
    if (grant_log.size() >= base + 6) begin
      for (int k = 0; k < 6; k++)
        chk($sformatf("rr_grant%0d", k), 32'(grant_log[base + k]), 32'(k % 2));
    end
    chk("rr_mem_040", mem[12'h040], 32'h55FEF00D);

    // be = 0 write: ack in I+1, RAM untouched.
    ce0 = ce_cnt;
    issue1(12'h060, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h0, 1, a);
    drain();
    repeat (3) @(negedge clk);
    chk("be0_ce_count", 32'(ce_cnt - ce0), 32'd0);

    // Reset during RMW_WAIT: no response, word unchanged, no write strobe.
    wre0 = wre_cnt;
    issue1(12'h050, 1'b1, 4'b0011, 32'hFFFFFFFF, 32'h0, 0, a);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rmw_state", 32'(state_o), 32'(RMW_WAIT));
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_mem_050", mem[12'h050], 32'h01020304);
    chk("midrst_wre_count", 32'(wre_cnt - wre0), 32'd0);

    // First contention after reset goes to port 0.
    base = grant_log.size();
    fork
      begin
        int x;
        issue0(12'h050, 32'h01020304, x);
      end
      begin
        int y;
        issue1(12'h010, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 3, y);
      end
    join
    drain();
    chk("post_reset_grant_count", 32'(grant_log.size() - base), 32'd2);
    if (grant_log.size() >= base + 1)
      chk("post_reset_first_grant", 32'(grant_log[base]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
